frame_shape_classifier: RTL and testbench
=========================================

// Module: frame_shape_classifier
// PURPOSE
//  Per-frame colour and shape classifier on the camera pixel stream (RGB332, one pixel per CLK while HREF high).
//  Splits each frame into NUM_BANDS horizontal bands and counts red and blue pixels per band.
//  At frame end it decides the treasure colour from frame totals and the shape from the band profile.
//  Drives the 3-bit RESULT code to the Arduino parallel link.
// PARAMETERS
//  PIX_W        8            pixel width
//  NUM_BANDS    3            horizontal bands per frame, >=3
//  BAND_HEIGHT  48           rows per band
//  CNT_W        16           counter width; all counters saturate at all-ones
//  RED_CODE     8'b11100000  exact pixel value classed red
//  BLUE_CODE    8'b00000011  exact pixel value classed blue
// PORTS
//  CLK           in   1          pixel clock
//  RESET         in   1          asynchronous, active-high
//  PIXEL_IN      in   PIX_W      pixel data, valid when HREF=1
//  HREF          in   1          row valid
//  VSYNC         in   1          frame sync; rising edge = end of frame
//  R_THRESH      in   CNT_W      min frame red count for colour "red"
//  B_THRESH      in   CNT_W      min frame blue count for colour "blue"
//  RESULT        out  3          [0] colour (1 red, 0 blue/none), [2:1] shape
//  RESULT_VALID  out  1          one-cycle pulse when RESULT updates
// BEHAVIOUR
//  - Reset: RESULT=0, RESULT_VALID=0, all counters 0, FSM=IDLE, VSYNC/HREF edge registers 0.
//  - Edges come from registered VSYNC/HREF compared with the current inputs.
//  - FSM: IDLE -(VSYNC fall)-> ACCUM -(VSYNC rise)-> EVAL -(1 cycle)-> HOLD -(VSYNC fall)-> ACCUM.
//    Entering ACCUM clears all counters. The partial frame after reset is discarded.
//  - ACCUM: on each CLK with HREF=1 and VSYNC=0:
//    - PIXEL_IN==RED_CODE increments red[band].
//    - PIXEL_IN==BLUE_CODE increments blue[band].
//    - Any other value is ignored.
//  - Row tracking: each HREF fall increments the row-in-band counter.
//    At BAND_HEIGHT-1 the counter wraps to 0 and band increments; band saturates at NUM_BANDS-1.
//    Extra rows fold into the last band. No divider is used.
//  - EVAL (one cycle): frame totals R and B are sums over bands, saturating.
//    - B>=B_THRESH selects blue (blue takes priority).
//    - Else R>=R_THRESH selects red.
//    - Else none: colour bit=0, shape=00.
//    - Dominant profile: t=band 0, m=band NUM_BANDS/2, b=band NUM_BANDS-1 of the selected colour.
//    - Shape is decided in priority order:
//      - 01 triangle if b > t + (t>>1).
//      - 11 diamond if m > t + (t>>1) and m > b + (b>>1).
//      - 10 square otherwise.
//  - Latency: VSYNC rise seen at cycle N; EVAL at N+1; RESULT and RESULT_VALID=1 at N+2.
//    RESULT holds until the next update.
//  - HREF high at the VSYNC rise: that pixel is not counted.
//    Glitch with VSYNC fall and rise in consecutive cycles: the empty frame evaluates to none.
//  - RESET mid-frame: returns to IDLE immediately; no RESULT_VALID for that frame.
// CONFIGURATION
//  - FRAME_DEBOUNCE_EN defined:
//    - The previous frame's evaluated code is kept in a register (reset 0).
//    - RESULT/RESULT_VALID update only when the current evaluated code equals it, i.e. two consecutive agreeing frames.
//    - Otherwise RESULT holds and no pulse is issued.
//  - FRAME_DEBOUNCE_EN undefined: RESULT updates and RESULT_VALID pulses every frame.
// STRUCTURE
//  - Shared package img_proc_pkg:
//    - shape localparams SHAPE_NONE=2'b00, SHAPE_TRI=2'b01, SHAPE_SQR=2'b10, SHAPE_DIA=2'b11
//    - RGB332 colour codes
//    - FSM state encoding
//  - Sub-module band_counter: one saturating red/blue counter pair with clear and band-enable.
//    Instantiated NUM_BANDS times via generate.
// TESTING
//  - Reset mid-ACCUM with 500 red pixels -> RESULT=000, no VALID; next full frame with no pixels of interest -> VALID, RESULT=000.
//  - 176x144 frame, 8000 red pixels in band 2 only, R_THRESH=7000 -> RESULT=011 (red triangle), VALID exactly at N+2.
//  - Blue 3000/3000/3000 per band, B_THRESH=8000 -> RESULT=100 (blue square).
//  - Red 1000/5000/1000, R_THRESH=6000 -> RESULT=111 (red diamond).
//  - Red and blue both above threshold -> colour bit 0 (blue priority).
//  - 65535+ red pixels in one band -> counter saturates; with FRAME_DEBOUNCE_EN, alternating triangle/square frames -> no VALID.

Source files
------------

// File: rtl/img_proc_pkg.sv
// img_proc_pkg: constants shared by the frame classifier.
//   - shape codes carried in RESULT[2:1]
//   - RGB332 colour codes used as default pixel classes
//   - FSM state encoding of the classifier
package img_proc_pkg;

    localparam logic [1:0] SHAPE_NONE = 2'b00;
    localparam logic [1:0] SHAPE_TRI  = 2'b01;
    localparam logic [1:0] SHAPE_SQR  = 2'b10;
    localparam logic [1:0] SHAPE_DIA  = 2'b11;

    // RGB332 layout: RRR_GGG_BB
    localparam logic [7:0] RGB332_RED  = 8'b111_000_00;
    localparam logic [7:0] RGB332_BLUE = 8'b000_000_11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EVAL  = 2'd2,
        ST_HOLD  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/band_counter.sv
// band_counter: one red/blue pixel counter pair for a single band.
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_clr               synchronous clear of both counters (wins over counting)
//   i_en                this band is the one currently being scanned
//   i_red, i_blue       current pixel matches the red / blue code
//   o_red_cnt,
//   o_blue_cnt          counts, saturating at all-ones
module band_counter
    import img_proc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_red,
    input  logic             i_blue,
    output logic [CNT_W-1:0] o_red_cnt,
    output logic [CNT_W-1:0] o_blue_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_red;
    logic [CNT_W-1:0] r_blue;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_red  <= '0;
            r_blue <= '0;
        end else if (i_clr) begin
            r_red  <= '0;
            r_blue <= '0;
        end else if (i_en) begin
            if (i_red && (r_red != '1))
                r_red <= r_red + CNT_ONE;
            if (i_blue && (r_blue != '1))
                r_blue <= r_blue + CNT_ONE;
        end
    end

    assign o_red_cnt  = r_red;
    assign o_blue_cnt = r_blue;

endmodule

// File: rtl/frame_shape_classifier.sv
// frame_shape_classifier: per-frame colour and shape classifier on an RGB332
// camera stream. Counts red/blue pixels per horizontal band, then at frame end
// picks the colour from frame totals and the shape from the band profile.
//   CLK, RESET      pixel clock, asynchronous active-high reset
//   PIXEL_IN        pixel data, valid while HREF=1
//   HREF, VSYNC     row valid, frame sync (VSYNC rise = end of frame)
//   R_THRESH,
//   B_THRESH        minimum frame totals for red / blue
//   RESULT          [0] colour (1 red), [2:1] shape code
//   RESULT_VALID    one-cycle pulse when RESULT updates
// Build option FRAME_DEBOUNCE_EN: publish a code only when two consecutive
// frames evaluate to the same code.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for the first frame start (VSYNC fall)
// ST_ACCUM | counting pixels and rows of the current frame
// ST_EVAL  | one cycle: classify the finished frame, register RESULT
// ST_HOLD  | RESULT held, waiting for the next frame start
module frame_shape_classifier
    import img_proc_pkg::*;
#(
    parameter int              PIX_W       = 8,
    parameter int              NUM_BANDS   = 3,
    parameter int              BAND_HEIGHT = 48,
    parameter int              CNT_W       = 16,
    parameter logic [PIX_W-1:0] RED_CODE   = PIX_W'(RGB332_RED),
    parameter logic [PIX_W-1:0] BLUE_CODE  = PIX_W'(RGB332_BLUE)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [PIX_W-1:0] PIXEL_IN,
    input  logic             HREF,
    input  logic             VSYNC,
    input  logic [CNT_W-1:0] R_THRESH,
    input  logic [CNT_W-1:0] B_THRESH,
    output logic [2:0]       RESULT,
    output logic             RESULT_VALID
);

    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int ROW_W  = (BAND_HEIGHT > 1) ? $clog2(BAND_HEIGHT) : 1;
    localparam int MID    = NUM_BANDS / 2;
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(BAND_HEIGHT - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);
    localparam logic [BAND_W-1:0] BAND_ONE  = BAND_W'(1);

    fsm_state_t        r_state;
    logic              r_vsync_d;
    logic              r_href_d;
    logic [ROW_W-1:0]  r_row;
    logic [BAND_W-1:0] r_band;
    logic [2:0]        r_result;
    logic              r_result_valid;
`ifdef FRAME_DEBOUNCE_EN
    logic [2:0]        r_prev_code;
`endif

    logic             w_vsync_rise;
    logic             w_vsync_fall;
    logic             w_href_fall;
    logic             w_clr;
    logic             w_count;
    logic             w_is_red;
    logic             w_is_blue;
    logic [CNT_W-1:0] w_red_cnt  [NUM_BANDS];
    logic [CNT_W-1:0] w_blue_cnt [NUM_BANDS];
    logic [CNT_W:0]   w_red_sum;
    logic [CNT_W:0]   w_blue_sum;
    logic [CNT_W-1:0] w_red_tot;
    logic [CNT_W-1:0] w_blue_tot;
    logic             w_sel_blue;
    logic             w_sel_red;
    logic [CNT_W-1:0] w_t;
    logic [CNT_W-1:0] w_m;
    logic [CNT_W-1:0] w_b;
    logic [CNT_W:0]   w_t_lim;
    logic [CNT_W:0]   w_b_lim;
    logic [1:0]       w_shape;
    logic [2:0]       w_code;

    assign w_vsync_rise = VSYNC & ~r_vsync_d;
    assign w_vsync_fall = ~VSYNC & r_vsync_d;
    assign w_href_fall  = ~HREF & r_href_d;

    // Counters are cleared on the same edge that enters ACCUM.
    assign w_clr     = ((r_state == ST_IDLE) || (r_state == ST_HOLD)) && w_vsync_fall;
    // VSYNC=0 here keeps a pixel coincident with the VSYNC rise out of the count.
    assign w_count   = (r_state == ST_ACCUM) && HREF && !VSYNC;
    assign w_is_red  = (PIXEL_IN == RED_CODE);
    assign w_is_blue = (PIXEL_IN == BLUE_CODE);

    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
        band_counter #(.CNT_W(CNT_W)) u_band (
            .i_clk      (CLK),
            .i_rst      (RESET),
            .i_clr      (w_clr),
            .i_en       (w_count && (r_band == BAND_W'(g))),
            .i_red      (w_is_red),
            .i_blue     (w_is_blue),
            .o_red_cnt  (w_red_cnt[g]),
            .o_blue_cnt (w_blue_cnt[g])
        );
    end

    // Saturating frame totals.
    always_comb begin
        w_red_tot  = '0;
        w_blue_tot = '0;
        w_red_sum  = '0;
        w_blue_sum = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            w_red_sum  = {1'b0, w_red_tot} + {1'b0, w_red_cnt[i]};
            w_red_tot  = w_red_sum[CNT_W] ? '1 : w_red_sum[CNT_W-1:0];
            w_blue_sum = {1'b0, w_blue_tot} + {1'b0, w_blue_cnt[i]};
            w_blue_tot = w_blue_sum[CNT_W] ? '1 : w_blue_sum[CNT_W-1:0];
        end
    end

    assign w_sel_blue = (w_blue_tot >= B_THRESH);
    assign w_sel_red  = !w_sel_blue && (w_red_tot >= R_THRESH);

    assign w_t = w_sel_blue ? w_blue_cnt[0]           : w_red_cnt[0];
    assign w_m = w_sel_blue ? w_blue_cnt[MID]         : w_red_cnt[MID];
    assign w_b = w_sel_blue ? w_blue_cnt[NUM_BANDS-1] : w_red_cnt[NUM_BANDS-1];

    // x + x/2 computed one bit wider so the 1.5x margin never wraps.
    assign w_t_lim = {1'b0, w_t} + {2'b00, w_t[CNT_W-1:1]};
    assign w_b_lim = {1'b0, w_b} + {2'b00, w_b[CNT_W-1:1]};

    always_comb begin
        w_shape = SHAPE_SQR;
        if (!(w_sel_blue || w_sel_red))
            w_shape = SHAPE_NONE;
        else if ({1'b0, w_b} > w_t_lim)
            w_shape = SHAPE_TRI;
        else if (({1'b0, w_m} > w_t_lim) && ({1'b0, w_m} > w_b_lim))
            w_shape = SHAPE_DIA;
    end

    assign w_code = {w_shape, w_sel_red};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= ST_IDLE;
            r_vsync_d      <= 1'b0;
            r_href_d       <= 1'b0;
            r_row          <= '0;
            r_band         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
`ifdef FRAME_DEBOUNCE_EN
            r_prev_code    <= '0;
`endif
        end else begin
            r_vsync_d      <= VSYNC;
            r_href_d       <= HREF;
            r_result_valid <= 1'b0;

            case (r_state)
                ST_IDLE:  if (w_vsync_fall) r_state <= ST_ACCUM;
                ST_ACCUM: if (w_vsync_rise) r_state <= ST_EVAL;
                ST_EVAL: begin
                    r_state <= ST_HOLD;
`ifdef FRAME_DEBOUNCE_EN
                    if (w_code == r_prev_code) begin
                        r_result       <= w_code;
                        r_result_valid <= 1'b1;
                    end
                    r_prev_code <= w_code;
`else
                    r_result       <= w_code;
                    r_result_valid <= 1'b1;
`endif
                end
                ST_HOLD:  if (w_vsync_fall) r_state <= ST_ACCUM;
                default:  r_state <= ST_IDLE;
            endcase

            // Rows past the last band fold into it; band never wraps.
            if (w_clr) begin
                r_row  <= '0;
                r_band <= '0;
            end else if ((r_state == ST_ACCUM) && w_href_fall) begin
                if (r_row == ROW_LAST) begin
                    r_row <= '0;
                    if (r_band != BAND_LAST)
                        r_band <= r_band + BAND_ONE;
                end else begin
                    r_row <= r_row + ROW_ONE;
                end
            end
        end
    end

    assign RESULT       = r_result;
    assign RESULT_VALID = r_result_valid;

endmodule

// File: tb/tb_frame_shape_classifier.sv
module tb_frame_shape_classifier;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  PIXEL_IN;
    logic        HREF;
    logic        VSYNC;
    logic [15:0] R_THRESH;
    logic [15:0] B_THRESH;
    logic [2:0]  RESULT;
    logic        RESULT_VALID;

    localparam logic [7:0] PX_RED   = 8'hE0;
    localparam logic [7:0] PX_BLUE  = 8'h03;
    localparam logic [7:0] PX_OTHER = 8'h55;

    frame_shape_classifier dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PIXEL_IN     (PIXEL_IN),
        .HREF         (HREF),
        .VSYNC        (VSYNC),
        .R_THRESH     (R_THRESH),
        .B_THRESH     (B_THRESH),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0] code;
        int         at;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] prev_code = 3'b000;
    logic [2:0] held_code = 3'b000;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            HREF     = 1'b0;
            PIXEL_IN = 8'h00;
        end
    endtask

    task automatic row(input logic [7:0] v, input int n_v, input int n_o);
        for (int i = 0; i < n_v; i++) begin
            @(negedge CLK);
            HREF = 1'b1; PIXEL_IN = v;
        end
        for (int i = 0; i < n_o; i++) begin
            @(negedge CLK);
            HREF = 1'b1; PIXEL_IN = PX_OTHER;
        end
        @(negedge CLK);
        HREF = 1'b0; PIXEL_IN = 8'h00;
    endtask

    task automatic short_rows(input int n);
        for (int i = 0; i < n; i++) row(PX_OTHER, 1, 0);
    endtask

    task automatic frame_begin();
        @(negedge CLK); VSYNC = 1'b1;
        idle(3);
        @(negedge CLK); VSYNC = 1'b0;
        idle(2);
    endtask

    // Model of the publish rule; the pulse is due two cycles after the rise.
    task automatic expect_code(input logic [2:0] code, input int c);
        exp_t e;
`ifdef FRAME_DEBOUNCE_EN
        if (code == prev_code) begin
            e.code = code; e.at = c + 2; q.push_back(e); held_code = code;
        end
        prev_code = code;
`else
        e.code = code; e.at = c + 2; q.push_back(e); held_code = code;
`endif
    endtask

    task automatic frame_end(input logic [2:0] code, input bit href_at_rise);
        check("result_hold", int'(RESULT), int'(held_code));
        @(negedge CLK);
        VSYNC = 1'b1;
        if (href_at_rise) begin
            HREF = 1'b1; PIXEL_IN = PX_RED;
        end
        expect_code(code, cyc);
        idle(5);
    endtask

    initial begin
        RESET = 1'b1; HREF = 1'b0; VSYNC = 1'b0; PIXEL_IN = 8'h00;
        R_THRESH = 16'd1; B_THRESH = 16'd1;
        fork
            begin : stim
                repeat (3) @(negedge CLK);
                check("reset_result", int'(RESULT), 0);
                check("reset_valid", int'(RESULT_VALID), 0);
                @(negedge CLK); RESET = 1'b0;

                // partial frame straight after reset is ignored
                row(PX_RED, 20, 0);
                @(negedge CLK); VSYNC = 1'b1;
                idle(4);

                // reset in the middle of a frame with 500 red pixels
                frame_begin();
                row(PX_RED, 250, 0);
                row(PX_RED, 250, 0);
                @(negedge CLK); RESET = 1'b1;
                @(negedge CLK);
                check("midreset_result", int'(RESULT), 0);
                check("midreset_valid", int'(RESULT_VALID), 0);
                RESET = 1'b0; prev_code = 3'b000; held_code = 3'b000;

                // full frame, nothing of interest -> none
                frame_begin();
                short_rows(144);
                frame_end(3'b000, 1'b0);

                // 176x144 style: 8000 red in band 2 -> red triangle
                R_THRESH = 16'd7000; B_THRESH = 16'hFFFF;
                frame_begin();
                short_rows(96);
                for (int i = 0; i < 45; i++) row(PX_RED, 176, 0);
                row(PX_RED, 80, 96);
                row(PX_OTHER, 176, 0);
                row(PX_OTHER, 176, 0);
                frame_end(3'b011, 1'b0);

                // blue 3000/3000/3000 -> blue square
                R_THRESH = 16'hFFFF; B_THRESH = 16'd8000;
                frame_begin();
                for (int b = 0; b < 3; b++) begin
                    row(PX_BLUE, 3000, 0);
                    short_rows(47);
                end
                frame_end(3'b100, 1'b0);

                // red 1000/5000/1000 -> red diamond
                R_THRESH = 16'd6000; B_THRESH = 16'hFFFF;
                frame_begin();
                row(PX_RED, 1000, 0); short_rows(47);
                row(PX_RED, 5000, 0); short_rows(47);
                row(PX_RED, 1000, 0);
                frame_end(3'b111, 1'b0);

                // both colours above threshold -> blue wins (square)
                R_THRESH = 16'd50; B_THRESH = 16'd50;
                frame_begin();
                row(PX_RED, 100, 0);
                row(PX_BLUE, 100, 0);
                frame_end(3'b100, 1'b0);

                // red pixel coincident with the VSYNC rise is not counted
                R_THRESH = 16'd3; B_THRESH = 16'hFFFF;
                frame_begin();
                row(PX_RED, 2, 0);
                frame_end(3'b000, 1'b1);

                // VSYNC glitch: fall then rise next cycle -> empty frame
                R_THRESH = 16'd1; B_THRESH = 16'd1;
                check("glitch_hold", int'(RESULT), int'(held_code));
                @(negedge CLK); VSYNC = 1'b1;
                idle(3);
                @(negedge CLK); VSYNC = 1'b0;
                @(negedge CLK); VSYNC = 1'b1;
                expect_code(3'b000, cyc);
                idle(5);

                // 65540 red in band 2 -> counter saturates at 65535 = R_THRESH
                R_THRESH = 16'hFFFF; B_THRESH = 16'hFFFF;
                frame_begin();
                short_rows(96);
                row(PX_RED, 65540, 0);
                frame_end(3'b011, 1'b0);

                // alternating triangle / square frames
                R_THRESH = 16'd5; B_THRESH = 16'hFFFF;
                for (int k = 0; k < 2; k++) begin
                    frame_begin();
                    short_rows(96);
                    row(PX_RED, 10, 0);
                    frame_end(3'b011, 1'b0);
                    frame_begin();
                    row(PX_RED, 10, 0);
                    frame_end(3'b101, 1'b0);
                end

                idle(10);
                check("pending_pulses", q.size(), 0);
            end
            begin : mon
                exp_t e;
                forever begin
                    @(negedge CLK);
                    if (!RESET && RESULT_VALID) begin
                        if (q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_valid: got pulse with RESULT=%b at cycle %0d, required none",
                                     RESULT, cyc);
                        end else begin
                            e = q.pop_front();
                            check("result_code", int'(RESULT), int'(e.code));
                            check("valid_cycle", cyc, e.at);
                        end
                    end
                end
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
